regfile_sb: RTL and testbench
=============================

# regfile_sb

Integer register file with an attached scoreboard, sitting between decode/issue and execute. It supplies `data_rs1`/`data_rs2` operands to the execute stage and accepts `data_rd` results at writeback. It also tracks which registers have an in-flight producer and gates instruction issue on RAW/WAW hazards. Writeback data is bypassed to the read ports in the same cycle.

## Interface
- NUM_REGS, 32, number of architectural registers; x0 hardwired to zero
- ADDR_W, 5, register index width ($clog2(NUM_REGS))

- clk_i  in  1  clock; all state updates on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- rs1_addr_i  in  ADDR_W  source 1 index of the instruction at issue
- rs2_addr_i  in  ADDR_W  source 2 index of the instruction at issue
- data_rs1_o  out  32 (bus32_t)  source 1 operand
- data_rs2_o  out  32 (bus32_t)  source 2 operand
- issue_valid_i  in  1  decode presents an instruction
- issue_use_rs1_i  in  1  instruction reads rs1
- issue_use_rs2_i  in  1  instruction reads rs2
- issue_we_i  in  1  instruction will write rd
- issue_rd_i  in  ADDR_W  destination index
- issue_ready_o  out  1  no hazard; instruction is accepted when issue_valid_i && issue_ready_o
- wb_valid_i  in  1  writeback strobe
- wb_rd_i  in  ADDR_W  writeback destination
- data_rd_i  in  32 (bus32_t)  writeback data
- busy_o  out  NUM_REGS  scoreboard bit vector (debug/verification)

## Operation
- Storage: NUM_REGS x 32 flops plus NUM_REGS busy bits. Entry 0 is not stored: it always reads 0, writes to it are dropped, and busy[0] is constant 0.
- Write: on a clock edge with wb_valid_i=1 and wb_rd_i!=0, regs[wb_rd_i] <= data_rd_i. This happens whether or not busy[wb_rd_i] is set.
- Read (combinational): data_rsN_o = 0 if addr==0; else data_rd_i if wb_valid_i && wb_rd_i==addr; else regs[addr].
- pending(r) = busy[r] && !(wb_valid_i && wb_rd_i==r). A writeback in the current cycle resolves the hazard.
- issue_ready_o = !(issue_use_rs1_i && pending(rs1_addr_i)) && !(issue_use_rs2_i && pending(rs2_addr_i)) && !(issue_we_i && pending(issue_rd_i)).
  - issue_ready_o does not depend on issue_valid_i.
- Accept = issue_valid_i && issue_ready_o.
- Busy update at edge, clear applied before set:
  - wb_valid_i clears busy[wb_rd_i].
  - Accept with issue_we_i && issue_rd_i!=0 sets busy[issue_rd_i].
  - Clear and set on the same index in the same cycle -> busy=1 (new producer).
- Writeback to a non-busy register is legal: data is written, busy stays 0.
- issue_valid_i with issue_ready_o=0 changes no state. Decode holds the instruction and retries.

## Timing
- Read ports: zero-latency combinational, including same-cycle bypass from writeback.
- issue_ready_o: combinational from busy, wb_*, issue_* inputs, and rs addresses. No registered stage.
- Busy set/clear becomes visible in busy_o and issue_ready_o the cycle after the edge.
- Written data is visible via regs from the cycle after the edge. In the write cycle itself it is visible via the bypass.
- Reset (rstn_i low, any time, including with writebacks in flight):
  - All regs and busy bits cleared asynchronously.
  - busy_o=0; data_rs*_o=0 for non-bypassed reads; issue_ready_o=1.
  - wb_valid_i and issue accepts are ignored while rstn_i=0.
  - Normal operation resumes at the first rising edge after deassertion.
- No multi-cycle paths. Every operation completes in one cycle.

## Test plan
- Reset then read: assert rstn_i low mid-run with busy[5]=1 and regs[5]=0xDEAD_BEEF, then release. Required: busy_o=0, data_rs1_o=0 for rs1_addr_i=5, issue_ready_o=1.
- Write/read and x0:
  - wb x7=0x1234_5678, then read rs1=7 next cycle -> 0x1234_5678.
  - wb x0=0xFFFF_FFFF -> rs2=0 reads 0, busy_o[0]=0.
- Same-cycle bypass: wb x3=0xA5A5_A5A5 with rs1_addr_i=3 in the same cycle. Required: data_rs1_o=0xA5A5_A5A5 that cycle; regs[3] holds it afterwards.
- RAW stall:
  - Issue rd=9 (we=1). Next cycle, issue use_rs1 with rs1=9 -> issue_ready_o=0, no state change.
  - Cycle with wb x9=0x42 -> issue_ready_o=1 and data_rs1_o=0x42 in that same cycle.
- WAW and simultaneous set/clear: busy[4]=1. Issue rd=4 we=1 with wb_rd_i=4 in the same cycle. Required: issue_ready_o=1, accepted, busy_o[4]=1 next cycle, regs[4]=wb data.
- Stalled issue leaves state intact: busy[2]=1, issue_valid_i=1, rd=6 we=1, use_rs1 rs1=2. Required: issue_ready_o=0 and busy_o[6] stays 0 over 3 cycles.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file with issue scoreboard: combinational reads with same-cycle writeback bypass,
// single-cycle writes, and RAW/WAW hazard gating of issue via issue_ready_o (combinational).
package regfile_sb_pkg;
  typedef logic [31:0] bus32_t;
endpackage

module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [ADDR_W-1:0]   rs1_addr_i,
  input  logic [ADDR_W-1:0]   rs2_addr_i,
  output bus32_t              data_rs1_o,
  output bus32_t              data_rs2_o,
  input  logic                issue_valid_i,
  input  logic                issue_use_rs1_i,
  input  logic                issue_use_rs2_i,
  input  logic                issue_we_i,
  input  logic [ADDR_W-1:0]   issue_rd_i,
  output logic                issue_ready_o,
  input  logic                wb_valid_i,
  input  logic [ADDR_W-1:0]   wb_rd_i,
  input  bus32_t              data_rd_i,
  output logic [NUM_REGS-1:0] busy_o
);

  // Entry 0 is never stored; index 0 reads as zero and its busy bit is tied low.
  bus32_t                regs   [1:NUM_REGS-1];
  logic [NUM_REGS-1:1]   busy_q;
  logic [NUM_REGS-1:1]   busy_nxt;
  logic [NUM_REGS-1:0]   pend;
  logic                  accept;

  assign busy_o = {busy_q, 1'b0};

  // A writeback in the current cycle resolves the hazard on its destination.
  always_comb begin
    pend = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      pend[i] = busy_q[i] && !(wb_valid_i && (wb_rd_i == ADDR_W'(i)));
    end
  end

  always_comb begin
    issue_ready_o = 1'b1;
    if (issue_use_rs1_i && pend[rs1_addr_i]) issue_ready_o = 1'b0;
    if (issue_use_rs2_i && pend[rs2_addr_i]) issue_ready_o = 1'b0;
    if (issue_we_i && pend[issue_rd_i])      issue_ready_o = 1'b0;
  end

  assign accept = issue_valid_i && issue_ready_o;

  // Clear before set so a same-index clear/set leaves the new producer marked busy.
  always_comb begin
    busy_nxt = busy_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wb_valid_i && (wb_rd_i == ADDR_W'(i))) busy_nxt[i] = 1'b0;
      if (accept && issue_we_i && (issue_rd_i == ADDR_W'(i))) busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      busy_q <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      busy_q <= busy_nxt;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wb_valid_i && (wb_rd_i == ADDR_W'(i))) regs[i] <= data_rd_i;
      end
    end
  end

  always_comb begin
    data_rs1_o = '0;
    data_rs2_o = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs1_addr_i == ADDR_W'(i)) data_rs1_o = regs[i];
      if (rs2_addr_i == ADDR_W'(i)) data_rs2_o = regs[i];
    end
    if (wb_valid_i && (wb_rd_i == rs1_addr_i) && (rs1_addr_i != '0)) data_rs1_o = data_rd_i;
    if (wb_valid_i && (wb_rd_i == rs2_addr_i) && (rs2_addr_i != '0)) data_rs2_o = data_rd_i;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: per-cycle vector table plus hand sequences for stall and reset.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic [31:0] d1, d2, wb_dat;
  logic        iv, u1, u2, we, rdy, wbv;
  logic [31:0] busy;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk_i(clk), .rstn_i(rstn),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2),
    .data_rs1_o(d1), .data_rs2_o(d2),
    .issue_valid_i(iv), .issue_use_rs1_i(u1), .issue_use_rs2_i(u2),
    .issue_we_i(we), .issue_rd_i(rd), .issue_ready_o(rdy),
    .wb_valid_i(wbv), .wb_rd_i(wb_rd), .data_rd_i(wb_dat),
    .busy_o(busy)
  );

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        iv, u1, u2, we;
    logic [4:0]  rd;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic [31:0] e_d1, e_d2;
    logic        e_rdy;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2,
                              input logic v, input logic s1, input logic s2, input logic w,
                              input logic [4:0] r, input logic wv, input logic [4:0] wr,
                              input logic [31:0] wd, input logic [31:0] x1, input logic [31:0] x2,
                              input logic xr, input logic [31:0] xb);
    vec_t t;
    t.rs1 = a1; t.rs2 = a2; t.iv = v; t.u1 = s1; t.u2 = s2; t.we = w; t.rd = r;
    t.wbv = wv; t.wbrd = wr; t.wbd = wd;
    t.e_d1 = x1; t.e_d2 = x2; t.e_rdy = xr; t.e_busy = xb;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    rs1 = t.rs1; rs2 = t.rs2; iv = t.iv; u1 = t.u1; u2 = t.u2; we = t.we; rd = t.rd;
    wbv = t.wbv; wb_rd = t.wbrd; wb_dat = t.wbd;
  endtask

  task automatic idle();
    rs1 = 0; rs2 = 0; iv = 0; u1 = 0; u2 = 0; we = 0; rd = 0; wbv = 0; wb_rd = 0; wb_dat = 0;
  endtask

  initial begin
    idle();
    //             rs1 rs2 iv u1 u2 we rd wbv wbrd wbd           e_d1          e_d2          rdy busy
    tbl[0]  = mk(0,  0,  0, 0, 0, 0, 0, 0, 0,  32'h0,        32'h0,        32'h0,        1, 32'h0);
    tbl[1]  = mk(7,  0,  0, 0, 0, 0, 0, 1, 7,  32'h12345678, 32'h12345678, 32'h0,        1, 32'h0);
    tbl[2]  = mk(7,  0,  0, 0, 0, 0, 0, 0, 0,  32'h0,        32'h12345678, 32'h0,        1, 32'h0);
    tbl[3]  = mk(0,  0,  0, 0, 0, 0, 0, 1, 0,  32'hFFFFFFFF, 32'h0,        32'h0,        1, 32'h0);
    tbl[4]  = mk(7,  0,  0, 0, 0, 0, 0, 0, 0,  32'h0,        32'h12345678, 32'h0,        1, 32'h0);
    tbl[5]  = mk(3,  0,  0, 0, 0, 0, 0, 1, 3,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        1, 32'h0);
    tbl[6]  = mk(3,  3,  0, 0, 0, 0, 0, 0, 0,  32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5, 1, 32'h0);
    tbl[7]  = mk(0,  0,  1, 0, 0, 1, 9, 0, 0,  32'h0,        32'h0,        32'h0,        1, 32'h0);
    tbl[8]  = mk(9,  0,  1, 1, 0, 0, 0, 0, 0,  32'h0,        32'h0,        32'h0,        0, 32'h200);
    tbl[9]  = mk(9,  0,  1, 1, 0, 0, 0, 0, 0,  32'h0,        32'h0,        32'h0,        0, 32'h200);
    tbl[10] = mk(9,  0,  1, 1, 0, 0, 0, 1, 9,  32'h42,       32'h42,       32'h0,        1, 32'h200);
    tbl[11] = mk(9,  0,  0, 0, 0, 0, 0, 0, 0,  32'h0,        32'h42,       32'h0,        1, 32'h0);
    tbl[12] = mk(0,  0,  1, 0, 0, 1, 4, 0, 0,  32'h0,        32'h0,        32'h0,        1, 32'h0);
    tbl[13] = mk(4,  0,  1, 0, 0, 1, 4, 1, 4,  32'h0BADF00D, 32'h0BADF00D, 32'h0,        1, 32'h10);
    tbl[14] = mk(4,  0,  0, 0, 0, 1, 4, 0, 0,  32'h0,        32'h0BADF00D, 32'h0,        0, 32'h10);
    tbl[15] = mk(0,  4,  0, 0, 0, 0, 0, 1, 4,  32'h11,       32'h0,        32'h11,       1, 32'h10);
    tbl[16] = mk(0,  4,  0, 0, 0, 0, 0, 0, 0,  32'h0,        32'h0,        32'h11,       1, 32'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 32'h0);
    chk("reset_ready", {31'b0, rdy}, 32'h1);
    rstn = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("v%0d_d1", i), d1, tbl[i].e_d1);
      chk($sformatf("v%0d_d2", i), d2, tbl[i].e_d2);
      chk($sformatf("v%0d_rdy", i), {31'b0, rdy}, {31'b0, tbl[i].e_rdy});
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
    end

    // Stalled issue must not mark its destination busy.
    @(posedge clk); #1;
    idle(); iv = 1; we = 1; rd = 2;
    @(negedge clk);
    chk("set2_rdy", {31'b0, rdy}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      idle(); iv = 1; we = 1; rd = 6; u1 = 1; rs1 = 2;
      @(negedge clk);
      chk($sformatf("stall%0d_rdy", k), {31'b0, rdy}, 32'h0);
      chk($sformatf("stall%0d_busy", k), busy, 32'h4);
    end

    // Load x5 with a value and a busy bit, then reset mid-run.
    @(posedge clk); #1;
    idle(); iv = 1; we = 1; rd = 5; wbv = 1; wb_rd = 5; wb_dat = 32'hDEADBEEF;
    @(negedge clk);
    chk("x5_rdy", {31'b0, rdy}, 32'h1);
    @(posedge clk); #1;
    idle(); rs1 = 5;
    @(negedge clk);
    chk("x5_data", d1, 32'hDEADBEEF);
    chk("x5_busy", busy, 32'h24);

    @(posedge clk); #2;
    rstn = 1'b0;
    wbv = 1; wb_rd = 5; wb_dat = 32'h77; iv = 1; we = 1; rd = 8; rs1 = 6;
    @(negedge clk);
    chk("inrst_busy", busy, 32'h0);
    chk("inrst_d1", d1, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("inrst_busy2", busy, 32'h0);
    idle(); rs1 = 5; u1 = 1; we = 1; rd = 2;
    rstn = 1'b1;
    #1;
    chk("post_rst_d1", d1, 32'h0);
    chk("post_rst_busy", busy, 32'h0);
    chk("post_rst_rdy", {31'b0, rdy}, 32'h1);
    @(posedge clk); #1;
    idle(); rs1 = 5;
    @(negedge clk);
    chk("post_rst_d1b", d1, 32'h0);
    chk("post_rst_busyb", busy, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
